// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns (a..g, active low)
// and the output polarity values used by the decoder and the scan top.
package sevenseg_pkg;

  localparam logic [0:6] SEG_0   = 7'b000_0001;
  localparam logic [0:6] SEG_1   = 7'b100_1111;
  localparam logic [0:6] SEG_2   = 7'b001_0010;
  localparam logic [0:6] SEG_3   = 7'b000_0110;
  localparam logic [0:6] SEG_4   = 7'b100_1100;
  localparam logic [0:6] SEG_5   = 7'b010_0100;
  localparam logic [0:6] SEG_6   = 7'b010_0000;
  localparam logic [0:6] SEG_7   = 7'b000_1111;
  localparam logic [0:6] SEG_8   = 7'b000_0000;
  localparam logic [0:6] SEG_9   = 7'b000_0100;
  localparam logic [0:6] SEG_A   = 7'b000_1000;
  localparam logic [0:6] SEG_B   = 7'b110_0000;
  localparam logic [0:6] SEG_C   = 7'b011_0001;
  localparam logic [0:6] SEG_D   = 7'b100_0010;
  localparam logic [0:6] SEG_E   = 7'b011_0000;
  localparam logic [0:6] SEG_F   = 7'b011_1000;
  localparam logic [0:6] SEG_OFF = 7'b111_1111;

  localparam logic AN_ON  = 1'b0;
  localparam logic AN_OFF = 1'b1;
  localparam logic DP_ON  = 1'b0;
  localparam logic DP_OFF = 1'b1;

endpackage

// File: rtl/sevenseg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern (bit 0 = segment a).
module sevenseg_hex_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [0:6] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous shadow capture.
// Define SEVENSEG_LZB_EN to blank leading zero digits above the most significant nonzero nibble.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] val,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [0:6]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;

  logic                    slot_end;
  logic                    frame_wrap;
  logic [3:0]              nibble;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    lz_blank;
  logic                    digit_off;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [0:6]              dec_seg;

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);

  // Counter, index and shadow all freeze together while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      sh_val   <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
    end else if (en) begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (frame_wrap) begin
        sh_val   <= val;
        sh_dp    <= dp_in;
        sh_blank <= blank;
      end
    end
  end

  // Select the active digit's shadow data; only the shadow ever feeds the display.
  always_comb begin
    nibble    = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_next   = {NUM_DIGITS{AN_OFF}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nibble     = sh_val[4*i +: 4];
        cur_dp     = sh_dp[i];
        cur_blank  = sh_blank[i];
        an_next[i] = AN_ON;
      end
    end
  end

`ifdef SEVENSEG_LZB_EN
  logic [IDX_W-1:0] lead;

  // Digit 0 can never exceed lead, so it is never blanked by this rule.
  always_comb begin
    lead = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sh_val[4*i +: 4] != 4'h0) lead = IDX_W'(i);
    end
    lz_blank = (idx > lead);
  end
`else
  assign lz_blank = 1'b0;
`endif

  assign digit_off = cur_blank || lz_blank;

  sevenseg_hex_decoder u_dec (
    .digit (nibble),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst || !en || digit_off) begin
      seg <= SEG_OFF;
      dp  <= DP_OFF;
      an  <= {NUM_DIGITS{AN_OFF}};
    end else begin
      seg <= dec_seg;
      dp  <= cur_dp ? DP_ON : DP_OFF;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench for sevenseg_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4); expectations
// adapt when SEVENSEG_LZB_EN is defined.
module tb_sevenseg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int FRAME = ND * RD;

  logic          clk;
  logic          rst;
  logic          en;
  logic [15:0]   val;
  logic [3:0]    dp_in;
  logic [3:0]    blank;
  logic [0:6]    seg;
  logic          dp;
  logic [3:0]    an;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed enabled cycles within the frame plus the latched frame data.
  int          m_n;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;

  logic [6:0] dec_tab [16];
  logic [3:0] scan_an [4];

  sevenseg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .val   (val),
    .dp_in (dp_in),
    .blank (blank),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic lz_off(input int d);
    int lead;
    lead = 0;
    for (int i = 0; i < ND; i++) if (m_val[4*i +: 4] != 4'h0) lead = i;
`ifdef SEVENSEG_LZB_EN
    return (d > lead);
`else
    return 1'b0;
`endif
  endfunction

  // One clock: predict outputs from the model, check them after the edge, then advance the model.
  task automatic tick();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         d;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (!rst && en) begin
      d = (m_n / RD) % ND;
      if (!m_blank[d] && !lz_off(d)) begin
        e_an  = ~(4'b0001 << d);
        e_seg = dec_tab[m_val[4*d +: 4]];
        e_dp  = ~m_dp[d];
      end
    end
    @(posedge clk);
    #1;
    check("model_an", 16'(an), 16'(e_an));
    check("model_seg", 16'(seg), 16'(e_seg));
    check("model_dp", 16'(dp), 16'(e_dp));
    if (rst) begin
      m_n     = 0;
      m_val   = '0;
      m_dp    = '0;
      m_blank = '0;
    end else if (en) begin
      if (m_n == FRAME - 1) begin
        m_val   = val;
        m_dp    = dp_in;
        m_blank = blank;
      end
      m_n = (m_n + 1) % FRAME;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic to_frame_start();
    for (int i = 0; i < FRAME && m_n != 0; i++) tick();
  endtask

  initial begin
    dec_tab = '{7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
                7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
                7'b000_0000, 7'b000_0100, 7'b000_1000, 7'b110_0000,
                7'b011_0001, 7'b100_0010, 7'b011_0000, 7'b011_1000};
    scan_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    m_n = 0; m_val = '0; m_dp = '0; m_blank = '0;
    rst = 1'b1; en = 1'b1; val = 16'h0; dp_in = 4'h0; blank = 4'h0;

    // Reset held three cycles.
    run(3);
    check("reset_an", 16'(an), 16'hF);
    check("reset_seg", 16'(seg), 16'h7F);
    check("reset_dp", 16'(dp), 16'h1);

    // First cycle after release shows digit 0 of the zeroed shadow.
    rst = 1'b0;
    tick();
    check("post_reset_an", 16'(an), 16'(4'b1110));
    check("post_reset_seg", 16'(seg), 16'(7'b000_0001));

    // Scan of 1234, two full periods.
    val = 16'h1234;
    run(FRAME - 1);
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick();
      check("scan_an", 16'(an), 16'(scan_an[(k / RD) % ND]));
      check("scan_seg", 16'(seg), 16'(dec_tab[4'((k / RD) % ND + 1) == 4'd1 ? 4 :
                                             ((k / RD) % ND == 1) ? 3 :
                                             ((k / RD) % ND == 2) ? 2 : 1]));
    end

    // Tear-free: change val while digit 2 is active.
    run(2 * RD);
    val = 16'h5678;
    for (int k = 2 * RD; k < FRAME; k++) begin
      tick();
      check("tear_old_seg", 16'(seg), 16'(((k / RD) == 2) ? 7'b001_0010 : 7'b100_1111));
    end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      check("tear_new_seg", 16'(seg), 16'(dec_tab[4'(8 - k / RD)]));
    end

    // Hex letters and decimal point.
    val = 16'hABCF; dp_in = 4'b0001;
    run(FRAME);
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if (k == 0) begin
        check("hex_d0_seg", 16'(seg), 16'(7'b011_1000));
        check("hex_d0_dp", 16'(dp), 16'h0);
      end
      if (k == 3 * RD) begin
        check("hex_d3_seg", 16'(seg), 16'(7'b000_1000));
        check("hex_d3_dp", 16'(dp), 16'h1);
      end
    end

    // Leading-zero handling.
    val = 16'h0050; dp_in = 4'h0;
    run(FRAME);
    for (int k = 0; k < FRAME; k++) begin
      tick();
`ifdef SEVENSEG_LZB_EN
      if (k >= 2 * RD) check("lzb_blank_an", 16'(an), 16'hF);
`else
      if (k >= 2 * RD) check("lzb_zero_seg", 16'(seg), 16'(7'b000_0001));
`endif
    end
    val = 16'h0000;
    run(FRAME);
    for (int k = 0; k < FRAME; k++) begin
      tick();
`ifdef SEVENSEG_LZB_EN
      if (k >= RD) check("lzb_all_zero_an", 16'(an), 16'hF);
      else check("lzb_digit0_an", 16'(an), 16'(4'b1110));
`else
      check("zero_seg", 16'(seg), 16'(7'b000_0001));
`endif
    end

    // Enable drop while digit 1 is active, resume with the remaining count.
    val = 16'h1234;
    run(FRAME);
    to_frame_start();
    run(RD + 1);
    en = 1'b0;
    tick();
    check("en_off_an", 16'(an), 16'hF);
    check("en_off_seg", 16'(seg), 16'h7F);
    run(9);
    en = 1'b1;
    for (int k = 0; k < RD - 1; k++) begin
      tick();
      check("en_resume_an", 16'(an), 16'(4'b1101));
    end
    tick();
    check("en_next_an", 16'(an), 16'(4'b1011));

    // Randomised traffic: values, decimal points, blanking and enable gaps.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 5) == 0) val = 16'($urandom);
      if ($urandom_range(0, 5) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 7) == 0) blank = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      en = ($urandom_range(0, 9) != 0);
      tick();
    end
    en = 1'b1; blank = 4'h0;

    // Reset mid-frame discards pending data; the next frame shows zeros.
    val = 16'h9999;
    run(6);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if (k == 0) check("midreset_an", 16'(an), 16'(4'b1110));
      if (an != 4'hF) check("midreset_seg", 16'(seg), 16'(7'b000_0001));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
